dec_to_bin: RTL and testbench

DEC_TO_BIN -- requirements
Module: dec_to_bin

---
 rtl/dec_to_bin.sv | 125 ++++++++++++
 tb/tb_dec_to_bin.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dec_to_bin.sv
// Three-digit BCD to binary converter using the reverse double-dabble algorithm.
// A 22-bit work register is shifted right and corrected for 10 cycles; the result saturates at 255.

module dec_to_bin_adj #(
  parameter int DIG_W = 4
) (
  input  logic [DIG_W-1:0] i_d,
  output logic [DIG_W-1:0] o_d
);
  // Undo the implicit x2 carried into a BCD field after a right shift.
  assign o_d = (i_d >= DIG_W'(8)) ? i_d - DIG_W'(3) : i_d;
endmodule

module dec_to_bin #(
  parameter int NUM_DIG = 3,
  parameter int DIG_W   = 4,
  parameter int BIN_W   = 10,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DIG_W-1:0] huns,
  input  logic [DIG_W-1:0] tens,
  input  logic [DIG_W-1:0] ones,
  output logic [OUT_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             err
);
  localparam int WORK_W = NUM_DIG*DIG_W + BIN_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                           r_state, w_state_nxt;
  logic [WORK_W-1:0]                r_work;
  logic [CNT_W-1:0]                 r_cnt;
  logic [OUT_W-1:0]                 r_binary;
  logic                             r_ovf, r_err;

  logic [WORK_W-1:0]                w_shift, w_work_nxt;
  logic [NUM_DIG-1:0][DIG_W-1:0]    w_dig_in, w_dig_out;
  logic [BIN_W-1:0]                 w_res;
  logic                             w_digits_ok, w_last;

  assign w_shift = r_work >> 1;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign w_dig_in[g] = w_shift[BIN_W + g*DIG_W +: DIG_W];
    dec_to_bin_adj #(.DIG_W(DIG_W)) u_adj (.i_d(w_dig_in[g]), .o_d(w_dig_out[g]));
  end

  assign w_work_nxt  = {w_dig_out, w_shift[BIN_W-1:0]};
  assign w_res       = w_work_nxt[BIN_W-1:0];
  assign w_last      = (r_cnt == CNT_W'(BIN_W-1));
  assign w_digits_ok = (huns <= DIG_W'(9)) && (tens <= DIG_W'(9)) && (ones <= DIG_W'(9));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_digits_ok ? S_SHIFT : S_DONE;
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_binary <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (w_digits_ok) begin
            r_work <= {huns, tens, ones, {BIN_W{1'b0}}};
            r_cnt  <= '0;
          end else begin
            r_binary <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_err <= 1'b0;
            if (w_res > BIN_W'(255)) begin
              r_binary <= '1;
              r_ovf    <= 1'b1;
            end else begin
              r_binary <= w_res[OUT_W-1:0];
              r_ovf    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign binary   = r_binary;
  assign overflow = r_ovf;
  assign err      = r_err;
endmodule

// File: tb/tb_dec_to_bin.sv
// Bench for dec_to_bin: directed corner cases plus random digits against an arithmetic model.
module tb_dec_to_bin;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] huns, tens, ones;
  logic [7:0] binary;
  logic       busy, done, overflow, err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_bin = '0;
  logic       exp_ov  = 1'b0;
  logic       exp_er  = 1'b0;

  dec_to_bin dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .huns(huns), .tens(tens), .ones(ones),
    .binary(binary), .busy(busy), .done(done),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int h, input int t, input int o,
                                output logic [7:0] b, output logic ov, output logic er);
    int v;
    v  = h*100 + t*10 + o;
    er = (h > 9) || (t > 9) || (o > 9);
    ov = !er && (v > 255);
    b  = er ? 8'd0 : (v > 255 ? 8'd255 : v[7:0]);
  endfunction

  // Called on a negedge with the block idle; returns on a negedge with the block idle again.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input bit glitch);
    logic [7:0] eb;
    logic       eo, ee;
    int         n, extra;
    model(h, t, o, eb, eo, ee);
    huns = h; tens = t; ones = o; start = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk);
    start = 1'b0;
    huns = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
    chk("busy_rise", busy, 1);
    while (!done && n < 30) begin
      if (glitch && n == 3) begin
        huns = 4'd9; tens = 4'd9; ones = 4'd9; start = 1'b1;
      end else start = 1'b0;
      if (n == 5) begin
        chk("hold_bin", binary, exp_bin);
        chk("hold_ovf", overflow, exp_ov);
        chk("hold_err", err, exp_er);
      end
      @(posedge clk); n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", n, ee ? 1 : 11);
    chk("binary", binary, eb);
    chk("overflow", overflow, eo);
    chk("err", err, ee);
    exp_bin = eb; exp_ov = eo; exp_er = ee;
    @(posedge clk); @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_idle", busy, 0);
    if (glitch) begin
      extra = 0;
      repeat (14) begin
        @(posedge clk); @(negedge clk);
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
    end
  endtask

  initial begin
    int n, pulses;
    reset_n = 1'b0; start = 1'b0; huns = '0; tens = '0; ones = '0;
    #23;
    chk("rst_bin", binary, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Start on the very first edge after release.
    run_conv(4'd1, 4'd2, 4'd3, 1'b0);
    chk("res_123", binary, 8'h7B);
    run_conv(4'd2, 4'd5, 4'd5, 1'b0);
    run_conv(4'd2, 4'd5, 4'd6, 1'b0);
    run_conv(4'd0, 4'd0, 4'd0, 1'b0);
    run_conv(4'd9, 4'd9, 4'd9, 1'b0);
    run_conv(4'd0, 4'hA, 4'd0, 1'b0);
    run_conv(4'd1, 4'd2, 4'd3, 1'b1);

    // Reset in the 5th SHIFT cycle after a saturating result.
    run_conv(4'd9, 4'd9, 4'd9, 1'b0);
    huns = 4'd1; tens = 4'd2; ones = 4'd3; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bin", binary, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_err", err, 0);
    exp_bin = '0; exp_ov = 1'b0; exp_er = 1'b0;
    pulses = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); if (done) pulses++; end
    reset_n = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); if (done) pulses++; end
    chk("rst_no_done", pulses, 0);
    run_conv(4'd0, 4'd4, 4'd2, 1'b0);
    chk("res_42", binary, 8'd42);

    // start held high: second conversion starts on the first IDLE edge.
    huns = 4'd0; tens = 4'd4; ones = 4'd2; start = 1'b1;
    n = 0; pulses = 0;
    while (pulses < 2 && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) begin
        pulses++;
        chk(pulses == 1 ? "b2b_lat1" : "b2b_lat2", n, pulses == 1 ? 11 : 23);
        chk("b2b_bin", binary, 8'd42);
      end
      if (n == 12) chk("b2b_idle_gap", busy, 0);
    end
    chk("b2b_pulses", pulses, 2);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_bin = 8'd42; exp_ov = 1'b0; exp_er = 1'b0;

    for (int i = 0; i < 40; i++)
      run_conv(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
               4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
